multicycle_maindec: RTL and testbench
=====================================

Name: multicycle_maindec

Overview:
- Multicycle successor to the single-cycle main decoder.
- A Moore-style control FSM with a memory-ready handshake sequences each MIPS instruction over 3–5 states: fetch, decode, execute, memory, writeback.
- It drives the datapath muxes and write enables.
- It flags illegal opcodes and counts retired instructions.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 4, aluop width; must be ≥4. The encodings below are zero-extended into the upper bits.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  OP_W  opcode from the instruction register.
- mem_ready  in  1  memory handshake; the current access completes in a cycle where this is 1.
- iord  out  1  memory address select (1 = ALUOut).
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- pcwrite  out  1  unconditional PC write.
- branch  out  1  conditional PC write (ANDed with zero externally).
- pcsrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- alusrca  out  1  ALU A select (1 = register A).
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- regdst  out  1  destination register select (1 = rd).
- regwrite  out  1  register file write.
- memtoreg  out  1  writeback source select (1 = MDR).
- zeroextend  out  1  immediate zero-extend.
- aluop  out  ALUOP_W  ALU operation.
- illegal_op  out  1  one-cycle pulse when the opcode is unsupported.
- instr_count  out  CNT_W  count of retired instructions.
- state_o  out  4  current state, for debug.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
  - RTYPEEX=6, RTYPEWB=7, BEQEX=8, IMMEX=9, IMMWB=10, JEX=11.
  - Codes 12–15 are unreachable; if entered, go to FETCH next cycle.
- Reset: state=FETCH, op_q=0, instr_count=0, illegal_op=0. reset has priority over every other event, including mid-instruction; an in-flight instruction is abandoned and not counted.
- Defaults: every output is 0 unless listed for the current state. Outputs are decoded from the state register; only FETCH is qualified by mem_ready.
- FETCH:
  - Outputs: alusrcb=01, aluop=0, pcsrc=00; irwrite=pcwrite=mem_ready.
  - Next state: DECODE if mem_ready, else stay in FETCH.
- DECODE:
  - Outputs: alusrcb=11, aluop=0.
  - op is latched into op_q. Later states use op_q only, never the live op.
  - Next state:
    - 0 → RTYPEEX; 2 → JEX; 4 → BEQEX.
    - 8, 9, 10, 12, 13, 14, 15 → IMMEX.
    - 35, 43 → MEMADR.
    - Any other opcode → FETCH, with illegal_op=1 in this cycle (combinational pulse).
- MEMADR:
  - Outputs: alusrca=1, alusrcb=10, aluop=0.
  - Next state: MEMRD if op_q=35, MEMWR if op_q=43.
- MEMRD:
  - Outputs: iord=1.
  - Next state: MEMWB on mem_ready, else hold.
- MEMWB:
  - Outputs: memtoreg=1, regwrite=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: iord=1, memwrite=1; both held high while waiting.
  - Next state: FETCH on mem_ready, else hold.
- RTYPEEX:
  - Outputs: alusrca=1, alusrcb=00, aluop=4'b1111.
  - Next state: RTYPEWB.
- RTYPEWB:
  - Outputs: regdst=1, regwrite=1.
  - Next state: FETCH.
- BEQEX:
  - Outputs: alusrca=1, alusrcb=00, aluop=4'b0001, branch=1, pcsrc=01.
  - Next state: FETCH.
- IMMEX:
  - Outputs: alusrca=1, alusrcb=10.
  - aluop by op_q: 8/9 → 0000, 10 → 0010, 12 → 0100, 13 → 0101, 14 → 0110, 15 → 0111.
  - zeroextend=1 for op_q 12–15.
  - Next state: IMMWB.
- IMMWB:
  - Outputs: regwrite=1, regdst=0; zeroextend as in IMMEX.
  - Next state: FETCH.
- JEX:
  - Outputs: pcsrc=10, pcwrite=1.
  - Next state: FETCH.
- instr_count:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR (with mem_ready), RTYPEWB, BEQEX, IMMWB or JEX.
  - Does not increment on an illegal opcode or on reset.
  - Wraps from all-ones to 0 with no flag.
- Latency with mem_ready tied to 1:
  - lw: 5 cycles.
  - R-type, immediate ops, sw: 4 cycles.
  - beq, j: 3 cycles.
- A change on op after DECODE has no effect on the in-flight instruction.
- mem_ready is ignored in states that do not access memory.

Test Plan:
- reset held 2 cycles, mem_ready=1, op=0 → state_o=0, all outputs 0 except FETCH set (alusrcb=01, irwrite=pcwrite=1), instr_count=0. R-type completes through states 0,1,6,7,0 with aluop=1111 in RTYPEEX and regdst=regwrite=1 in RTYPEWB; instr_count=1.
- op=35, mem_ready low for 3 cycles in MEMRD → state_o holds 3 with iord=1 for 3 cycles, then MEMWB with memtoreg=regwrite=1; total 8 cycles; count +1.
- Each immediate opcode 8, 9, 10, 12, 13, 14, 15 → IMMEX aluop = 0000, 0000, 0010, 0100, 0101, 0110, 0111 respectively; zeroextend=1 only for 12–15; regwrite in IMMWB.
- op=43 then op changed to 4 during MEMADR → MEMWR still entered, memwrite=1, no branch asserted.
- op=63 → illegal_op=1 for exactly the DECODE cycle; back to FETCH; instr_count unchanged.
- reset asserted in MEMRD → FETCH next cycle, instr_count=0.
- Separately: CNT_W=2 with 5 beq instructions → instr_count=1 (wrap).

Source files
------------

// File: rtl/multicycle_maindec.sv
// Multicycle MIPS main decoder: Moore control FSM with a memory-ready
// handshake, illegal-opcode flag and a retired-instruction counter.
//
// state   | meaning
// --------+---------------------------------------------------------
// FETCH   | read instruction, PC+4; advance when memory is ready
// DECODE  | latch opcode, precompute branch target, dispatch
// MEMADR  | compute load/store address
// MEMRD   | load data read, wait for memory
// MEMWB   | write loaded data to register file
// MEMWR   | store data write, wait for memory
// RTYPEEX | R-type ALU operation
// RTYPEWB | R-type result writeback to rd
// BEQEX   | compare and conditionally branch
// IMMEX   | immediate ALU operation
// IMMWB   | immediate result writeback to rt
// JEX     | jump
module multicycle_maindec #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               branch,
  output logic [1:0]         pcsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               regdst,
  output logic               regwrite,
  output logic               memtoreg,
  output logic               zeroextend,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instr_count,
  output logic [3:0]         state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);

  state_t            state_q;
  logic [OP_W-1:0]   op_q;
  logic [CNT_W-1:0]  cnt_q;
  state_t            dispatch_d;
  logic              op_bad;
  logic              retire;
  logic              imm_zext;
  logic [3:0]        aluop4;

  // Opcode dispatch out of DECODE, looked up on the live opcode.
  always_comb begin
    dispatch_d = S_FETCH;
    op_bad     = 1'b0;
    case (op)
      OP_RTYPE:                        dispatch_d = S_RTYPEEX;
      OP_J:                            dispatch_d = S_JEX;
      OP_BEQ:                          dispatch_d = S_BEQEX;
      OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: dispatch_d = S_IMMEX;
      OP_LW, OP_SW:                    dispatch_d = S_MEMADR;
      default:                         op_bad     = 1'b1;
    endcase
  end

  // An instruction retires on the last cycle before returning to FETCH.
  always_comb begin
    case (state_q)
      S_MEMWB, S_RTYPEWB, S_BEQEX, S_IMMWB, S_JEX: retire = 1'b1;
      S_MEMWR:                                      retire = mem_ready;
      default:                                      retire = 1'b0;
    endcase
  end

  // State register, latched opcode and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_FETCH:   if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          op_q    <= op;
          state_q <= dispatch_d;
        end
        S_MEMADR: begin
          if (op_q == OP_LW)      state_q <= S_MEMRD;
          else if (op_q == OP_SW) state_q <= S_MEMWR;
          else                    state_q <= S_FETCH;
        end
        S_MEMRD:   if (mem_ready) state_q <= S_MEMWB;
        S_MEMWR:   if (mem_ready) state_q <= S_FETCH;
        S_RTYPEEX: state_q <= S_RTYPEWB;
        S_IMMEX:   state_q <= S_IMMWB;
        default:   state_q <= S_FETCH;
      endcase
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign imm_zext = (op_q == OP_ANDI) || (op_q == OP_ORI) ||
                    (op_q == OP_XORI) || (op_q == OP_LUI);

  // Moore output decode; only FETCH looks at mem_ready.
  always_comb begin
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    zeroextend = 1'b0;
    aluop4     = 4'b0000;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop4  = 4'b1111;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop4  = 4'b0001;
        branch  = 1'b1;
        pcsrc   = 2'b01;
      end
      S_IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        zeroextend = imm_zext;
        case (op_q)
          OP_SLTI: aluop4 = 4'b0010;
          OP_ANDI: aluop4 = 4'b0100;
          OP_ORI:  aluop4 = 4'b0101;
          OP_XORI: aluop4 = 4'b0110;
          OP_LUI:  aluop4 = 4'b0111;
          default: aluop4 = 4'b0000;
        endcase
      end
      S_IMMWB: begin
        regwrite   = 1'b1;
        zeroextend = imm_zext;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign aluop       = ALUOP_W'(aluop4);
  assign illegal_op  = (state_q == S_DECODE) && op_bad && !reset;
  assign instr_count = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Directed bench for multicycle_maindec; a second instance with a 2-bit
// counter covers counter wrap.
module tb_multicycle_maindec;

  logic        clk = 1'b0;
  logic        reset, reset2, mem_ready;
  logic [5:0]  op;

  logic        iord, memwrite, irwrite, pcwrite, branch, alusrca;
  logic        regdst, regwrite, memtoreg, zeroextend, illegal_op;
  logic [1:0]  pcsrc, alusrcb;
  logic [3:0]  aluop, state_o;
  logic [15:0] instr_count;

  logic        d2_iord, d2_memwrite, d2_irwrite, d2_pcwrite, d2_branch, d2_alusrca;
  logic        d2_regdst, d2_regwrite, d2_memtoreg, d2_zeroextend, d2_illegal_op;
  logic [1:0]  d2_pcsrc, d2_alusrcb;
  logic [3:0]  d2_aluop, d2_state_o;
  logic [1:0]  d2_instr_count;

  logic [17:0] ctl;
  int          n_tests = 0;
  int          n_fail  = 0;

  // ctl field order: iord memwrite irwrite pcwrite branch pcsrc alusrca alusrcb
  //                  regdst regwrite memtoreg zeroextend aluop
  localparam logic [17:0] C_FETCH    = 18'b0_0_1_1_0_00_0_01_0_0_0_0_0000;
  localparam logic [17:0] C_FETCH_NR = 18'b0_0_0_0_0_00_0_01_0_0_0_0_0000;
  localparam logic [17:0] C_DECODE   = 18'b0_0_0_0_0_00_0_11_0_0_0_0_0000;
  localparam logic [17:0] C_MEMADR   = 18'b0_0_0_0_0_00_1_10_0_0_0_0_0000;
  localparam logic [17:0] C_MEMRD    = 18'b1_0_0_0_0_00_0_00_0_0_0_0_0000;
  localparam logic [17:0] C_MEMWB    = 18'b0_0_0_0_0_00_0_00_0_1_1_0_0000;
  localparam logic [17:0] C_MEMWR    = 18'b1_1_0_0_0_00_0_00_0_0_0_0_0000;
  localparam logic [17:0] C_RTYPEEX  = 18'b0_0_0_0_0_00_1_00_0_0_0_0_1111;
  localparam logic [17:0] C_RTYPEWB  = 18'b0_0_0_0_0_00_0_00_1_1_0_0_0000;
  localparam logic [17:0] C_BEQEX    = 18'b0_0_0_0_1_01_1_00_0_0_0_0_0001;
  localparam logic [17:0] C_JEX      = 18'b0_0_0_1_0_10_0_00_0_0_0_0_0000;

  assign ctl = {iord, memwrite, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb,
                regdst, regwrite, memtoreg, zeroextend, aluop};

  always #5 clk = ~clk;

  multicycle_maindec u_dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
    .branch(branch), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .regdst(regdst), .regwrite(regwrite), .memtoreg(memtoreg),
    .zeroextend(zeroextend), .aluop(aluop), .illegal_op(illegal_op),
    .instr_count(instr_count), .state_o(state_o)
  );

  multicycle_maindec #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset2), .op(op), .mem_ready(mem_ready),
    .iord(d2_iord), .memwrite(d2_memwrite), .irwrite(d2_irwrite), .pcwrite(d2_pcwrite),
    .branch(d2_branch), .pcsrc(d2_pcsrc), .alusrca(d2_alusrca), .alusrcb(d2_alusrcb),
    .regdst(d2_regdst), .regwrite(d2_regwrite), .memtoreg(d2_memtoreg),
    .zeroextend(d2_zeroextend), .aluop(d2_aluop), .illegal_op(d2_illegal_op),
    .instr_count(d2_instr_count), .state_o(d2_state_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cyc(input string tag, input logic [3:0] st, input logic [17:0] c);
    #1;
    check({tag, "_st"}, 32'(state_o), 32'(st));
    check({tag, "_ctl"}, 32'(ctl), 32'(c));
  endtask

  // Immediate opcodes with their IMMEX aluop and zero-extend expectation.
  logic [5:0] imm_op  [7] = '{6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15};
  logic [3:0] imm_alu [7] = '{4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
  logic       imm_z   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    reset = 1'b1; reset2 = 1'b1; mem_ready = 1'b1; op = 6'd0;
    step(); step();
    chk_cyc("rst", 4'd0, C_FETCH);
    check("rst_cnt", 32'(instr_count), 0);
    check("rst_ill", 32'(illegal_op), 0);
    reset = 1'b0;

    // R-type, op=0
    chk_cyc("r_f", 4'd0, C_FETCH);     step();
    chk_cyc("r_d", 4'd1, C_DECODE);    step();
    chk_cyc("r_ex", 4'd6, C_RTYPEEX);  step();
    chk_cyc("r_wb", 4'd7, C_RTYPEWB);  step();
    chk_cyc("r_end", 4'd0, C_FETCH);
    check("r_cnt", 32'(instr_count), 1);

    // fetch stall, then lw with three not-ready cycles in MEMRD
    mem_ready = 1'b0;
    chk_cyc("f_stall", 4'd0, C_FETCH_NR); step();
    chk_cyc("f_hold", 4'd0, C_FETCH_NR);
    mem_ready = 1'b1; op = 6'd35;
    chk_cyc("lw_f", 4'd0, C_FETCH);    step();
    chk_cyc("lw_d", 4'd1, C_DECODE);   step();
    op = 6'd0; mem_ready = 1'b0;
    chk_cyc("lw_adr", 4'd2, C_MEMADR); step();
    for (int i = 0; i < 3; i++) begin
      chk_cyc("lw_wait", 4'd3, C_MEMRD); step();
    end
    mem_ready = 1'b1;
    chk_cyc("lw_rd", 4'd3, C_MEMRD);   step();
    chk_cyc("lw_wb", 4'd4, C_MEMWB);   step();
    chk_cyc("lw_end", 4'd0, C_FETCH);
    check("lw_cnt", 32'(instr_count), 2);

    // immediates; live op scrambled after DECODE
    for (int k = 0; k < 7; k++) begin
      op = imm_op[k];
      chk_cyc("imm_f", 4'd0, C_FETCH);  step();
      chk_cyc("imm_d", 4'd1, C_DECODE);
      check("imm_ill", 32'(illegal_op), 0);
      step();
      op = 6'd63;
      chk_cyc("imm_ex", 4'd9, {10'b0_0_0_0_0_00_1_10, 3'b000, imm_z[k], imm_alu[k]});
      step();
      chk_cyc("imm_wb", 4'd10, {10'b0_0_0_0_0_00_0_00, 3'b010, imm_z[k], 4'b0000});
      step();
      check("imm_cnt", 32'(instr_count), 32'(3 + k));
    end

    // sw with op changed to beq during MEMADR, one not-ready cycle
    op = 6'd43;
    chk_cyc("sw_f", 4'd0, C_FETCH);    step();
    chk_cyc("sw_d", 4'd1, C_DECODE);   step();
    op = 6'd4;
    chk_cyc("sw_adr", 4'd2, C_MEMADR); step();
    mem_ready = 1'b0;
    chk_cyc("sw_wait", 4'd5, C_MEMWR);
    check("sw_br", 32'(branch), 0);
    step();
    mem_ready = 1'b1;
    chk_cyc("sw_wr", 4'd5, C_MEMWR);   step();
    chk_cyc("sw_end", 4'd0, C_FETCH);
    check("sw_cnt", 32'(instr_count), 10);

    // illegal opcode
    op = 6'd63;
    chk_cyc("ill_f", 4'd0, C_FETCH);   step();
    chk_cyc("ill_d", 4'd1, C_DECODE);
    check("ill_pulse", 32'(illegal_op), 1);
    step();
    chk_cyc("ill_end", 4'd0, C_FETCH);
    check("ill_low", 32'(illegal_op), 0);
    check("ill_cnt", 32'(instr_count), 10);

    // jump
    op = 6'd2;
    chk_cyc("j_f", 4'd0, C_FETCH);     step();
    chk_cyc("j_d", 4'd1, C_DECODE);    step();
    chk_cyc("j_ex", 4'd11, C_JEX);     step();
    chk_cyc("j_end", 4'd0, C_FETCH);
    check("j_cnt", 32'(instr_count), 11);

    // beq
    op = 6'd4;
    chk_cyc("b_f", 4'd0, C_FETCH);     step();
    chk_cyc("b_d", 4'd1, C_DECODE);    step();
    chk_cyc("b_ex", 4'd8, C_BEQEX);    step();
    chk_cyc("b_end", 4'd0, C_FETCH);
    check("b_cnt", 32'(instr_count), 12);

    // reset while waiting in MEMRD
    op = 6'd35;
    step(); step(); step();
    mem_ready = 1'b0;
    chk_cyc("rm_rd", 4'd3, C_MEMRD);
    reset = 1'b1;
    step();
    chk_cyc("rm_st", 4'd0, C_FETCH_NR);
    check("rm_cnt", 32'(instr_count), 0);
    mem_ready = 1'b1;
    reset = 1'b0; reset2 = 1'b0;
    #1;
    check("w_cnt0", 32'(d2_instr_count), 0);

    // five beqs: 16-bit counter reaches 5, 2-bit counter wraps to 1
    op = 6'd4;
    for (int n = 0; n < 5; n++) begin
      step(); step(); step();
    end
    #1;
    check("w_st", 32'(d2_state_o), 0);
    check("w_cnt16", 32'(instr_count), 5);
    check("w_cnt2", 32'(d2_instr_count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
